dram_rr_arbiter: RTL and testbench
==================================

# dram_rr_arbiter

Round-robin arbiter that shares the single DRAM/memory port between `NCORES` cores using a per-core request/grant handshake. It replaces implicit instruction-sniffing handoff with explicit requests, a quantum-based preemption timer, lock support for atomic read-modify-write sequences, and a one-cycle grant-switch bubble. It sits between the cores' bus outputs and the DRAM controller. Its `w_grant_id` drives the address/data/control muxes and the return-path demux.

## Interface
- `NCORES`, 2, number of requesters (1..8).
- `QUANTUM`, 16, cycles an owner may hold the port while another core waits (2..255).
- `CLK`  in  1  system clock, rising edge.
- `RST_X`  in  1  asynchronous, active-low reset.
- `w_req`  in  NCORES  per-core access request, level; held until the core no longer needs the port.
- `w_lock`  in  NCORES  per-core lock (AMO sequence). While the owner's bit is high, the grant is never taken away; a set lock bit also counts as a request.
- `w_dram_busy`  in  1  DRAM controller transaction in flight.
- `w_gnt`  out  NCORES  one-hot grant, registered.
- `w_grant_id`  out  3  index of current/last owner, registered; mux select.
- `w_gnt_valid`  out  1  high when some `w_gnt` bit is high.
- `w_preempt`  out  1  one-cycle pulse when a grant ends by quantum expiry.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: owner holds the port.
  - DRAIN: release decided, waiting for DRAM idle.
  - SWITCH: one bubble cycle, `w_gnt`=0.
- Effective request: `ereq[i] = w_req[i] | w_lock[i]`. `others` = any `ereq` bit other than the owner's.
- Round-robin pick: the first set `ereq` bit scanning from `last+1` upward, wrapping modulo NCORES. `last` is the previous owner. The previous owner is eligible only if no other core requests.
- IDLE: if any `ereq`, pick the winner; next state GRANT with `w_gnt[winner]`=1, `w_grant_id`=winner, `cnt`=0.
- GRANT:
  - `cnt` (8 bit) increments each cycle `others`=1 and saturates at QUANTUM-1. It holds when `others`=0.
  - Release conditions:
    - (a) owner `ereq`=0, or
    - (b) `cnt`==QUANTUM-1 and `others`=1 and `w_lock[owner]`=0.
  - On release: if `w_dram_busy`=0, go to SWITCH; else go to DRAIN.
  - Release reason (b) is latched into `pre_r`.
- DRAIN: `w_gnt` stays asserted. Go to SWITCH on the first cycle `w_dram_busy`=0. A re-raised owner request does not cancel the release.
- SWITCH:
  - `w_gnt`=0, `w_gnt_valid`=0, `last`=owner, `w_preempt`=`pre_r`.
  - Next state: GRANT to the pick if any `ereq`, else IDLE.
  - `cnt` and `pre_r` are cleared.
- Lock asserted during DRAIN (release already decided) is ignored; the lock is honoured on the core's next grant.
- Single requester: it may be re-granted after the SWITCH bubble; no preemption occurs because `others`=0.

## Timing
- Reset values, asynchronous: state=IDLE, `w_gnt`=0, `w_grant_id`=0, `w_gnt_valid`=0, `w_preempt`=0, `cnt`=0, `last`=NCORES-1, so core 0 wins first.
- Reset mid-transaction drops the grant immediately. In-flight DRAM state is the controller's responsibility.
- Request-to-grant latency from IDLE: `ereq` seen at edge t gives `w_gnt` high after edge t+1.
- Handoff: release decided at edge t with DRAM idle gives SWITCH during cycle t+1 and the new grant from edge t+2. The minimum gap between grants to different cores is exactly 1 cycle.
- With DRAM busy: handoff is delayed by the number of busy cycles in DRAIN.
- Preemption point: owner is granted at edge g while another core requests continuously. `cnt` reaches QUANTUM-1 at edge g+QUANTUM-1, and release is decided there.
- `w_preempt` is high for exactly the SWITCH cycle.
- Simultaneous release and new request from the owner: the release still happens; the owner re-competes in SWITCH.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `w_req`=2'b11 at cycle 5 → `w_gnt`=01, `w_grant_id`=0 after the next edge. Then `w_req[0]` drops → one cycle `w_gnt`=00, then `w_gnt`=10.
- QUANTUM=16, both cores request continuously, `w_dram_busy`=0 → grant alternates 01 → 00 → 10 → 00 … Each grant lasts 16 cycles, with a `w_preempt` pulse in every bubble.
- Same as above but `w_lock[0]`=1 for 40 cycles → core 0 holds the grant ≥40 cycles with no preempt. Release follows within QUANTUM cycles of lock deassertion.
- Owner releases while `w_dram_busy`=1 for 5 cycles → `w_gnt` stays asserted 5 extra cycles (DRAIN), then 1-cycle bubble, then the other core is granted.
- NCORES=4, `w_req`=4'b1011 continuously, last=0 → grant order 1, 3, 0, 1, 3 …; core 2 is never granted.
- Assert `RST_X`=0 asynchronously mid-grant → `w_gnt`=0 and `w_gnt_valid`=0 before the next clock edge. After release, core 0 is granted first.

Source files
------------

// File: rtl/dram_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_rr_arbiter_if
// Bundles the per-core request/lock inputs, the DRAM busy flag and the grant
// outputs of the shared DRAM port arbiter.
//   w_req       [NCORES] per-core level request
//   w_lock      [NCORES] per-core lock (atomic sequence); also acts as request
//   w_dram_busy          DRAM controller has a transaction in flight
//   w_gnt       [NCORES] one-hot grant (registered)
//   w_grant_id  [3]      current/last owner index, mux select
//   w_gnt_valid          some grant bit is high
//   w_preempt            one-cycle pulse when a grant ended by quantum expiry
// Modports: slave = arbiter side, master = cores/controller side.
// -----------------------------------------------------------------------------
interface dram_rr_arbiter_if #(
  parameter int NCORES = 2
);
  logic [NCORES-1:0] w_req;
  logic [NCORES-1:0] w_lock;
  logic              w_dram_busy;
  logic [NCORES-1:0] w_gnt;
  logic [2:0]        w_grant_id;
  logic              w_gnt_valid;
  logic              w_preempt;

  modport slave (
    input  w_req,
    input  w_lock,
    input  w_dram_busy,
    output w_gnt,
    output w_grant_id,
    output w_gnt_valid,
    output w_preempt
  );

  modport master (
    output w_req,
    output w_lock,
    output w_dram_busy,
    input  w_gnt,
    input  w_grant_id,
    input  w_gnt_valid,
    input  w_preempt
  );
endinterface

// File: rtl/dram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dram_rr_arbiter
// Round-robin arbiter sharing one DRAM port between NCORES cores. An owner
// keeps the port while it requests (or holds its lock); when another core is
// waiting, a quantum timer forces a handoff after QUANTUM cycles unless the
// owner is locked. A release waits for the DRAM controller to go idle (DRAIN)
// and is always followed by a one-cycle bubble (SWITCH) with no grant.
// Ports:
//   CLK    system clock, rising edge
//   RST_X  asynchronous active-low reset
//   bus    dram_rr_arbiter_if.slave (requests, locks, busy in; grants out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module dram_rr_arbiter #(
  parameter int NCORES  = 2,
  parameter int QUANTUM = 16
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  dram_rr_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_DRAIN  = 2'd2,
    S_SWITCH = 2'd3
  } state_e;

  localparam logic [7:0] CNT_MAX  = 8'(QUANTUM - 1);
  localparam logic [2:0] LAST_RST = 3'(NCORES - 1);

  state_e            state_q, state_d;
  logic [NCORES-1:0] gnt_q, gnt_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [2:0]        last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pre_q, pre_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              preempt_q, preempt_d;

  logic [NCORES-1:0] ereq;
  logic [NCORES-1:0] owner_oh;
  logic              others;
  logic              own_req;
  logic              own_lock;
  logic              quantum_hit;

  logic [2:0]        pick_base;
  logic [NCORES-1:0] hi_mask;
  logic [NCORES-1:0] pick_src;
  logic [2:0]        pick_id;
  logic [NCORES-1:0] pick_oh;
  logic              pick_found;

  // A held lock counts as a request so an atomic sequence never loses the port.
  assign ereq = bus.w_req | bus.w_lock;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_owner
      assign owner_oh[gi] = (grant_id_q == 3'(gi));
    end
  endgenerate

  assign others      = |(ereq & ~owner_oh);
  assign own_req     = |(ereq & owner_oh);
  assign own_lock    = |(bus.w_lock & owner_oh);
  assign quantum_hit = (cnt_q == CNT_MAX) && others && !own_lock;

  // In SWITCH the outgoing owner becomes "last" on this very edge, so the
  // pick has to rotate from the owner rather than the stale last_q.
  assign pick_base  = (state_q == S_SWITCH) ? grant_id_q : last_q;
  assign pick_found = |ereq;

  // Two-mask round robin: prefer requesters above the base; if none, wrap
  // to the lowest requester. The base itself is therefore lowest priority.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NCORES; i++) begin
      hi_mask[i] = (i > int'(pick_base));
    end
    pick_src = (|(ereq & hi_mask)) ? (ereq & hi_mask) : ereq;
    pick_id  = 3'd0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        pick_id = 3'(i);
      end
    end
    pick_oh = '0;
    for (int i = 0; i < NCORES; i++) begin
      pick_oh[i] = (pick_id == 3'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    grant_id_d  = grant_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    last_d      = last_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_GRANT;
          gnt_d       = pick_oh;
          grant_id_d  = pick_id;
          gnt_valid_d = 1'b1;
          cnt_d       = 8'd0;
        end
      end

      S_GRANT: begin
        // The timer only runs while someone else is waiting.
        if (others && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!own_req || quantum_hit) begin
          // A voluntary drop is not reported as a preemption.
          pre_d = quantum_hit && own_req;
          if (!bus.w_dram_busy) begin
            state_d     = S_SWITCH;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            preempt_d   = quantum_hit && own_req;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Release is already committed; requests and locks are not re-examined.
        if (!bus.w_dram_busy) begin
          state_d     = S_SWITCH;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          preempt_d   = pre_q;
        end
      end

      S_SWITCH: begin
        last_d = grant_id_q;
        cnt_d  = 8'd0;
        pre_d  = 1'b0;
        if (pick_found) begin
          state_d     = S_GRANT;
          gnt_d       = pick_oh;
          grant_id_d  = pick_id;
          gnt_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      grant_id_q  <= 3'd0;
      last_q      <= LAST_RST;
      cnt_q       <= 8'd0;
      pre_q       <= 1'b0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.w_gnt       = gnt_q;
  assign bus.w_grant_id  = grant_id_q;
  assign bus.w_gnt_valid = gnt_valid_q;
  assign bus.w_preempt   = preempt_q;

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_rr_arbiter
// Directed bench: a 2-core arbiter (QUANTUM=16) for handoff, quantum, lock,
// DRAIN and async reset behaviour, and a 4-core arbiter (QUANTUM=4) for
// round-robin order. Inputs change and outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dram_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_rr_arbiter_if #(.NCORES(2)) bus_a ();
  dram_rr_arbiter_if #(.NCORES(4)) bus_b ();

  dram_rr_arbiter #(.NCORES(2), .QUANTUM(16)) dut_a (
    .CLK   (clk),
    .RST_X (rst_n),
    .bus   (bus_a)
  );

  dram_rr_arbiter #(.NCORES(4), .QUANTUM(4)) dut_b (
    .CLK   (clk),
    .RST_X (rst_n),
    .bus   (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts consecutive samples with w_gnt == gexp, then checks the bubble.
  task automatic measure(input string tag, input logic [1:0] gexp,
                         input int len_exp, input logic pre_exp);
    int n;
    n = 0;
    while (bus_a.w_gnt == gexp && n < 100) begin
      n++;
      step();
    end
    check({tag, " len"}, n, len_exp);
    check({tag, " bubble gnt"}, bus_a.w_gnt, 0);
    check({tag, " bubble preempt"}, bus_a.w_preempt, pre_exp);
    step();
  endtask

  initial begin
    int n;
    int got;
    int order[6];
    int exp_order[6];
    logic prev_valid;
    logic saw2;

    exp_order = '{0, 1, 3, 0, 1, 3};
    bus_a.w_req = 2'b00;  bus_a.w_lock = 2'b00;  bus_a.w_dram_busy = 1'b0;
    bus_b.w_req = 4'b0000; bus_b.w_lock = 4'b0000; bus_b.w_dram_busy = 1'b0;

    // Reset state
    step(2);
    check("rst gnt", bus_a.w_gnt, 0);
    check("rst gnt_valid", bus_a.w_gnt_valid, 0);
    check("rst grant_id", bus_a.w_grant_id, 0);
    check("rst preempt", bus_a.w_preempt, 0);
    #2 rst_n = 1'b1;
    step(3);

    // First grant goes to core 0, then voluntary handoff with 1-cycle bubble
    bus_a.w_req = 2'b11;
    step();
    check("first gnt", bus_a.w_gnt, 2'b01);
    check("first id", bus_a.w_grant_id, 0);
    check("first valid", bus_a.w_gnt_valid, 1);
    bus_a.w_req = 2'b10;
    step();
    check("drop bubble gnt", bus_a.w_gnt, 2'b00);
    check("drop bubble valid", bus_a.w_gnt_valid, 0);
    check("drop bubble preempt", bus_a.w_preempt, 0);
    step();
    check("handoff gnt", bus_a.w_gnt, 2'b10);
    check("handoff id", bus_a.w_grant_id, 1);

    // Both request continuously: 16-cycle grants with preempt pulses
    bus_a.w_req = 2'b11;
    measure("quantum c1", 2'b10, 16, 1'b1);
    check("quantum next gnt", bus_a.w_gnt, 2'b01);
    measure("quantum c0", 2'b01, 16, 1'b1);
    measure("quantum c1b", 2'b10, 16, 1'b1);
    check("lock start gnt", bus_a.w_gnt, 2'b01);

    // Lock holds core 0 for 40 cycles; release right after lock drops
    bus_a.w_lock = 2'b01;
    n = 0;
    while (bus_a.w_gnt == 2'b01 && n < 200) begin
      n++;
      if (n == 40) bus_a.w_lock = 2'b00;
      step();
    end
    check("lock hold len", n, 40);
    check("lock bubble gnt", bus_a.w_gnt, 0);
    check("lock bubble preempt", bus_a.w_preempt, 1);
    step();
    check("after lock gnt", bus_a.w_gnt, 2'b10);

    // Core 1 releases while DRAM busy for 5 cycles
    bus_a.w_req = 2'b01;
    bus_a.w_dram_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("drain gnt %0d", i), bus_a.w_gnt, 2'b10);
    end
    bus_a.w_dram_busy = 1'b0;
    step();
    check("drain bubble gnt", bus_a.w_gnt, 2'b00);
    check("drain bubble preempt", bus_a.w_preempt, 0);
    step();
    check("after drain gnt", bus_a.w_gnt, 2'b01);
    check("after drain id", bus_a.w_grant_id, 0);

    // Single requester is never preempted
    step(30);
    check("single hold gnt", bus_a.w_gnt, 2'b01);
    check("single preempt", bus_a.w_preempt, 0);
    bus_a.w_req = 2'b00;
    step();
    check("single drop gnt", bus_a.w_gnt, 2'b00);
    step();
    check("idle gnt", bus_a.w_gnt, 2'b00);
    check("idle valid", bus_a.w_gnt_valid, 0);
    check("idle id", bus_a.w_grant_id, 0);

    // 4 cores, 1011 requesting: order 0,1,3,0,1,3; core 2 never granted
    bus_b.w_req = 4'b1011;
    got = 0; n = 0; prev_valid = 1'b0; saw2 = 1'b0;
    while (got < 6 && n < 200) begin
      if (bus_b.w_gnt_valid && !prev_valid) begin
        order[got] = int'(bus_b.w_grant_id);
        got++;
      end
      if (bus_b.w_gnt[2]) saw2 = 1'b1;
      prev_valid = bus_b.w_gnt_valid;
      step();
      n++;
    end
    check("rr4 grant count", got, 6);
    for (int i = 0; i < got; i++) begin
      check($sformatf("rr4 order %0d", i), order[i], exp_order[i]);
    end
    check("rr4 core2 never", saw2, 0);

    // Asynchronous reset mid-grant
    bus_a.w_req = 2'b11;
    n = 0;
    while (!bus_a.w_gnt_valid && n < 50) begin
      n++;
      step();
    end
    check("pre-reset valid", bus_a.w_gnt_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst gnt", bus_a.w_gnt, 0);
    check("async rst valid", bus_a.w_gnt_valid, 0);
    #2 rst_n = 1'b1;
    step();
    check("post-reset gnt", bus_a.w_gnt, 2'b01);
    check("post-reset id", bus_a.w_grant_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
